// File: rtl/mdio_phy_responder_pkg.sv
// Shared definitions for the Clause-22 MDIO PHY responder: opcodes, special
// register addresses, REGCR function codes and frame-receiver state encoding.
`timescale 1ns/1ps
package mdio_phy_responder_pkg;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam logic [4:0] REGAD_PHYID1 = 5'h02;
  localparam logic [4:0] REGAD_PHYID2 = 5'h03;
  localparam logic [4:0] REGAD_REGCR  = 5'h0d;
  localparam logic [4:0] REGAD_ADDAR  = 5'h0e;

  localparam logic [1:0] FN_ADDR        = 2'b00;
  localparam logic [1:0] FN_DATA        = 2'b01;
  localparam logic [1:0] FN_DATA_INC_RW = 2'b10;
  localparam logic [1:0] FN_DATA_INC_WR = 2'b11;

  localparam logic [4:0] DEVAD_EXT = 5'h1f;

  typedef logic [2:0] state_t;

  localparam state_t ST_PRE  = 3'd0;
  localparam state_t ST_ST2  = 3'd1;
  localparam state_t ST_OP   = 3'd2;
  localparam state_t ST_PHY  = 3'd3;
  localparam state_t ST_REG  = 3'd4;
  localparam state_t ST_TA   = 3'd5;
  localparam state_t ST_DATA = 3'd6;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad signals plus the register-write notification port of the responder.
`timescale 1ns/1ps
interface mdio_phy_responder_if;
  // wr_stb is a single-cycle pulse with no backpressure; wr_ext, wr_addr and
  // wr_data qualify it in the same cycle and hold their value afterwards.
  logic        mdc_in;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic        wr_stb;
  logic        wr_ext;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  modport slave (
    input  mdc_in, mdio_in,
    output mdio_out, mdio_oe, wr_stb, wr_ext, wr_addr, wr_data
  );

  modport master (
    output mdc_in, mdio_in,
    input  mdio_out, mdio_oe, wr_stb, wr_ext, wr_addr, wr_data
  );
endinterface

// File: rtl/mdio_frame_rx.sv
// MDC/MDIO frame receiver: synchronizers, edge detect, frame FSM and the read
// shift-out path. Raises rd_req at the last REG bit and wr_req at the last DATA bit.
`timescale 1ns/1ps
module mdio_frame_rx
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [4:0] PHY_AD  = 5'b00011,
  parameter int         PRE_LEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_out_o,
  output logic        mdio_oe_o,
  output logic        rd_req_o,
  output logic        wr_req_o,
  output logic [4:0]  regad_o,
  output logic [15:0] wr_data_o,
  input  logic [15:0] rd_data_i,
  output state_t      state_o
);

  localparam int PCW = $clog2(PRE_LEN + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(PRE_LEN);

  logic [2:0]     mdc_sync_q;
  logic [1:0]     mdio_sync_q;
  logic           rise, fall, bit_in;

  state_t         state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]     op_q, op_d;
  logic [3:0]     phy_q, phy_d;
  logic [4:0]     regad_q, regad_d;
  logic [14:0]    data_q, data_d;
  logic           rd_frame_q, rd_frame_d;
  logic           wr_frame_q, wr_frame_d;
  logic [15:0]    tx_q, tx_d;
  logic           oe_q, oe_d;
  logic           out_q, out_d;
  logic [4:0]     phy_next, reg_next;
  logic [1:0]     op_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[1:0], mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
    end
  end

  assign rise   = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign fall   = ~mdc_sync_q[1] & mdc_sync_q[2];
  assign bit_in = mdio_sync_q[1];

  assign phy_next = {phy_q, bit_in};
  assign reg_next = {regad_q[3:0], bit_in};
  assign op_next  = {op_q[0], bit_in};

  assign rd_req_o  = rise && (state_q == ST_REG) && (bit_cnt_q == 4'd4) && rd_frame_q;
  assign wr_req_o  = rise && (state_q == ST_DATA) && (bit_cnt_q == 4'd15) && wr_frame_q;
  assign regad_o   = (state_q == ST_REG) ? reg_next : regad_q;
  assign wr_data_o = {data_q, bit_in};

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_d       = op_q;
    phy_d      = phy_q;
    regad_d    = regad_q;
    data_d     = data_q;
    rd_frame_d = rd_frame_q;
    wr_frame_d = wr_frame_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    out_d      = out_q;
    if (rise) begin
      case (state_q)
        ST_PRE: begin
          if (bit_in) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            if (pre_cnt_q == PRE_MAX) state_d = ST_ST2;
            pre_cnt_d = '0;
          end
        end
        ST_ST2: begin
          bit_cnt_d = '0;
          state_d   = bit_in ? ST_OP : ST_PRE;
        end
        ST_OP: begin
          op_d = op_next;
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            state_d   = (op_next == OP_WR || op_next == OP_RD) ? ST_PHY : ST_PRE;
          end
        end
        ST_PHY: begin
          phy_d = phy_next[3:0];
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d  = '0;
            state_d    = ST_REG;
            rd_frame_d = (phy_next == PHY_AD) && (op_q == OP_RD);
            wr_frame_d = (phy_next == PHY_AD) && (op_q == OP_WR);
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_REG: begin
          regad_d = reg_next;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = ST_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_TA: begin
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          data_d = wr_data_o[14:0];
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d  = '0;
            pre_cnt_d  = '0;
            state_d    = ST_PRE;
            rd_frame_d = 1'b0;
            wr_frame_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_PRE;
      endcase
    end
    // Drive changes only on falling MDC so the station samples stable data on rise.
    if (fall) begin
      if (state_q == ST_TA && bit_cnt_q == 4'd1 && rd_frame_q) begin
        oe_d  = 1'b1;
        out_d = 1'b0;
      end else if (state_q == ST_DATA && rd_frame_q) begin
        out_d = tx_q[15];
        tx_d  = {tx_q[14:0], 1'b0};
      end else if (oe_q) begin
        oe_d  = 1'b0;
        out_d = 1'b1;
      end
    end
    if (rd_req_o) tx_d = rd_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_PRE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_q       <= '0;
      phy_q      <= '0;
      regad_q    <= '0;
      data_q     <= '0;
      rd_frame_q <= 1'b0;
      wr_frame_q <= 1'b0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      phy_q      <= phy_d;
      regad_q    <= regad_d;
      data_q     <= data_d;
      rd_frame_q <= rd_frame_d;
      wr_frame_q <= wr_frame_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
    end
  end

  assign mdio_oe_o  = oe_q;
  assign mdio_out_o = out_q;
  assign state_o    = state_q;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: 32x16 direct register file plus an extended
// bank reached through REGCR/ADDAR indirect access.
`timescale 1ns/1ps
module mdio_phy_responder
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [4:0]  PHY_AD  = 5'b00011,
  parameter int          PRE_LEN = 32,
  parameter int          EXT_AW  = 8,
  parameter logic [15:0] PHYID1  = 16'h2000,
  parameter logic [15:0] PHYID2  = 16'hA231
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mdio_phy_responder_if.slave mdio_bus,
  output state_t              dbg_state_o
);

  logic              rd_req, wr_req;
  logic [4:0]        regad;
  logic [15:0]       wr_data, rd_data;

  logic [15:0]       regs_q [32];
  logic [15:0]       ext_q [2**EXT_AW];
  logic [15:0]       ptr_q, ptr_d;
  logic              wr_stb_q, wr_stb_d;
  logic              wr_ext_q, wr_ext_d;
  logic [15:0]       wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              dir_we, ext_we;
  logic [1:0]        fn;
  logic              ext_ok;
  logic [EXT_AW-1:0] ext_idx;

  mdio_frame_rx #(
    .PHY_AD  (PHY_AD),
    .PRE_LEN (PRE_LEN)
  ) u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mdc_i      (mdio_bus.mdc_in),
    .mdio_i     (mdio_bus.mdio_in),
    .mdio_out_o (mdio_bus.mdio_out),
    .mdio_oe_o  (mdio_bus.mdio_oe),
    .rd_req_o   (rd_req),
    .wr_req_o   (wr_req),
    .regad_o    (regad),
    .wr_data_o  (wr_data),
    .rd_data_i  (rd_data),
    .state_o    (dbg_state_o)
  );

  assign fn      = regs_q[REGAD_REGCR][15:14];
  assign ext_ok  = (regs_q[REGAD_REGCR][4:0] == DEVAD_EXT);
  assign ext_idx = ptr_q[EXT_AW-1:0];

  always_comb begin
    rd_data = regs_q[regad];
    if (regad == REGAD_PHYID1) begin
      rd_data = PHYID1;
    end else if (regad == REGAD_PHYID2) begin
      rd_data = PHYID2;
    end else if (regad == REGAD_ADDAR) begin
      if (fn == FN_ADDR)  rd_data = ptr_q;
      else if (ext_ok)    rd_data = ext_q[ext_idx];
      else                rd_data = '0;
    end
  end

  always_comb begin
    dir_we    = 1'b0;
    ext_we    = 1'b0;
    ptr_d     = ptr_q;
    wr_stb_d  = 1'b0;
    wr_ext_d  = wr_ext_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_req) begin
      if (regad == REGAD_ADDAR) begin
        if (fn == FN_ADDR) begin
          ptr_d     = wr_data;
          wr_stb_d  = 1'b1;
          wr_ext_d  = 1'b0;
          wr_addr_d = {11'b0, regad};
          wr_data_d = wr_data;
        end else if (ext_ok) begin
          ext_we    = 1'b1;
          wr_stb_d  = 1'b1;
          wr_ext_d  = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = wr_data;
          if (fn == FN_DATA_INC_RW || fn == FN_DATA_INC_WR) ptr_d = ptr_q + 16'd1;
        end
      end else if (regad != REGAD_PHYID1 && regad != REGAD_PHYID2) begin
        dir_we    = 1'b1;
        wr_stb_d  = 1'b1;
        wr_ext_d  = 1'b0;
        wr_addr_d = {11'b0, regad};
        wr_data_d = wr_data;
      end
    end else if (rd_req && regad == REGAD_ADDAR && fn == FN_DATA_INC_RW && ext_ok) begin
      ptr_d = ptr_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      ptr_q     <= '0;
      wr_stb_q  <= 1'b0;
      wr_ext_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (dir_we) regs_q[regad] <= wr_data;
      ptr_q     <= ptr_d;
      wr_stb_q  <= wr_stb_d;
      wr_ext_q  <= wr_ext_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**EXT_AW; i++) ext_q[i] <= '0;
    end else if (ext_we) begin
      ext_q[ext_idx] <= wr_data;
    end
  end

  assign mdio_bus.wr_stb  = wr_stb_q;
  assign mdio_bus.wr_ext  = wr_ext_q;
  assign mdio_bus.wr_addr = wr_addr_q;
  assign mdio_bus.wr_data = wr_data_q;

endmodule
